// File: rtl/frame_packer_multi.sv
// Frame packer: emits one 16-bit word per clock, {side[5:0], sample[9:0]}. The side channel
// carries a framed stream: sync, audio snapshot chunks, CRC-12 of those chunks, sequence number.
module frame_packer_multi #(
  parameter int          NUM_CH    = 2,
  parameter int          FRAME_LEN = 512,
  parameter logic [47:0] SYNC      = 48'hDEADBEEFCAFE,
  parameter int          SEQ_SHIFT = 16,
  parameter int          SEQ_MAX   = 62,
  parameter int          TEST_WRAP = 1021
) (
  input  logic                 clock,
  input  logic                 nReset,
  input  logic [9:0]           adc_databus,
  input  logic [1:0]           testMode,
  input  logic [NUM_CH*12-1:0] audio_in,
  input  logic                 audio_ready,
  output logic [15:0]          dataOut,
  output logic                 frameStart,
  output logic                 audioFresh,
  output logic                 audioOverrun
);

  localparam int              PW       = $clog2(FRAME_LEN);
  localparam int              SEQ_W    = SEQ_SHIFT + 6;
  localparam int              AW       = NUM_CH * 12;
  localparam int              CRC_POS  = 8 + 2 * NUM_CH;
  localparam logic [PW-1:0]   LAST_POS = PW'(FRAME_LEN - 1);
  localparam logic [SEQ_W-1:0] SEQ_TOP = SEQ_W'(((SEQ_MAX + 1) << SEQ_SHIFT) - 1);
  localparam logic [9:0]      TEST_TOP = 10'(TEST_WRAP - 1);

  // CRC-12, poly 0x80F, six message bits per call, MSB first
  function automatic logic [11:0] crc12_6(input logic [11:0] crc, input logic [5:0] chunk);
    logic [11:0] c;
    logic        fb;
    c = crc;
    for (int i = 5; i >= 0; i--) begin
      fb = c[11] ^ chunk[i];
      c  = {c[10:0], 1'b0} ^ (fb ? 12'h80F : 12'h000);
    end
    return c;
  endfunction

  logic [PW-1:0]    pos_r, slot_s;
  logic [SEQ_W-1:0] seq_r;
  logic [9:0]       test_r, sample_s;
  logic [AW-1:0]    pending_r, snapshot_r;
  logic [11:0]      crc_r, ch_word_s;
  logic             seen_r, last_s, audio_slot_s;
  logic [5:0]       sync_chunk_s, chunk_s, side_s;

  // Side-channel and sample selection for the word being built this cycle
  always_comb begin
    last_s       = (pos_r == LAST_POS);
    slot_s       = pos_r - PW'(8);
    audio_slot_s = (pos_r >= PW'(8)) && (pos_r < PW'(CRC_POS));
    sync_chunk_s = 6'd0;
    for (int p = 0; p < 8; p++) begin
      sync_chunk_s = sync_chunk_s | (SYNC[6*p +: 6] & {6{pos_r[2:0] == 3'(p)}});
    end
    ch_word_s = 12'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_word_s = ch_word_s | (snapshot_r[12*c +: 12] & {12{slot_s[PW-1:1] == (PW-1)'(c)}});
    end
    chunk_s = slot_s[0] ? ch_word_s[5:0] : ch_word_s[11:6];
    if (pos_r < PW'(8)) begin
      side_s = sync_chunk_s;
    end else if (audio_slot_s) begin
      side_s = chunk_s;
    end else if (pos_r == PW'(CRC_POS)) begin
      side_s = crc_r[11:6];
    end else if (pos_r == PW'(CRC_POS + 1)) begin
      side_s = crc_r[5:0];
    end else begin
      side_s = seq_r[SEQ_SHIFT +: 6];
    end
    case (testMode)
      2'd0:    sample_s = adc_databus;
      2'd1:    sample_s = test_r;
      2'd2:    sample_s = 10'h200;
      2'd3:    sample_s = test_r[0] ? 10'h2AA : 10'h155;
      default: sample_s = adc_databus;
    endcase
  end

  // Free-running counters: frame position, sequence number, test ramp
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      pos_r  <= {PW{1'b0}};
      seq_r  <= {SEQ_W{1'b0}};
      test_r <= 10'd0;
    end else begin
      pos_r  <= last_s ? {PW{1'b0}} : pos_r + PW'(1);
      seq_r  <= (seq_r == SEQ_TOP) ? {SEQ_W{1'b0}} : seq_r + SEQ_W'(1);
      test_r <= (test_r == TEST_TOP) ? 10'd0 : test_r + 10'd1;
    end
  end

  // Audio capture; a strobe on the last word of a frame bypasses pending straight to the snapshot
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      pending_r    <= {AW{1'b0}};
      snapshot_r   <= {AW{1'b0}};
      seen_r       <= 1'b0;
      audioFresh   <= 1'b0;
      audioOverrun <= 1'b0;
    end else begin
      if (audio_ready) begin
        pending_r <= audio_in;
      end
      if (audio_ready && seen_r) begin
        audioOverrun <= 1'b1;
      end
      if (last_s) begin
        snapshot_r <= audio_ready ? audio_in : pending_r;
        audioFresh <= seen_r | audio_ready;
        seen_r     <= 1'b0;
      end else if (audio_ready) begin
        seen_r <= 1'b1;
      end
    end
  end

  // Running CRC over the audio chunks as they are emitted
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      crc_r <= 12'd0;
    end else if (pos_r == PW'(7)) begin
      crc_r <= 12'd0;
    end else if (audio_slot_s) begin
      crc_r <= crc12_6(crc_r, chunk_s);
    end
  end

  // Output word register
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      dataOut    <= 16'd0;
      frameStart <= 1'b0;
    end else begin
      dataOut    <= {side_s, sample_s};
      frameStart <= (pos_r == {PW{1'b0}});
    end
  end

endmodule

// File: tb/tb_frame_packer_multi.sv
// Bench for frame_packer_multi: a per-word scoreboard fed by a behavioural model, plus
// scenario checks for audio snapshot, CRC, overrun, bypass, sequence and mid-frame reset.
module tb_frame_packer_multi;

  logic        clock       = 1'b0;
  logic        nReset      = 1'b0;
  logic [9:0]  adc_databus = 10'd0;
  logic [1:0]  testMode    = 2'd0;
  logic [23:0] audio_in    = 24'd0;
  logic        audio_ready = 1'b0;
  logic [15:0] dataOut, dataOut2;
  logic        frameStart, frameStart2, audioFresh, audioFresh2, audioOverrun, audioOverrun2;

  frame_packer_multi #(.NUM_CH(2)) dut (
    .clock(clock), .nReset(nReset), .adc_databus(adc_databus), .testMode(testMode),
    .audio_in(audio_in), .audio_ready(audio_ready), .dataOut(dataOut),
    .frameStart(frameStart), .audioFresh(audioFresh), .audioOverrun(audioOverrun)
  );

  frame_packer_multi #(.NUM_CH(2), .SEQ_SHIFT(2), .SEQ_MAX(3)) dut2 (
    .clock(clock), .nReset(nReset), .adc_databus(adc_databus), .testMode(testMode),
    .audio_in(audio_in), .audio_ready(audio_ready), .dataOut(dataOut2),
    .frameStart(frameStart2), .audioFresh(audioFresh2), .audioOverrun(audioOverrun2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] data;
    logic [15:0] data2;
    logic        fs;
    logic        fresh;
    logic        over;
    int          pos;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_idx;
  logic [23:0] m_pend, m_snap;
  logic        m_seen, m_fresh, m_over;
  logic [47:0] sync_c = 48'hDEADBEEFCAFE;
  logic [1:0]  seq_pat [16] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                                2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

  // Bit-serial reference CRC-12 (poly 0x80F, init 0) over a message sent MSB first
  function automatic logic [11:0] crc_ref(input logic [23:0] msg);
    logic [11:0] c;
    c = 12'd0;
    for (int i = 23; i >= 0; i--) begin
      if (c[11] ^ msg[i]) c = {c[10:0], 1'b0} ^ 12'h80F;
      else                c = {c[10:0], 1'b0};
    end
    return c;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_pend = 24'd0; m_snap = 24'd0;
    m_seen = 1'b0; m_fresh = 1'b0; m_over = 1'b0;
    exp_q.delete();
  endtask

  // Drive one word's inputs, push the expected output, then advance one clock
  task automatic cyc(input logic [1:0] mode, input logic [9:0] adc, input logic rdy,
                     input logic [23:0] ain);
    exp_t        e;
    int          pos;
    logic [9:0]  ramp, samp;
    logic [5:0]  side, side2;
    logic [11:0] crc;
    testMode = mode; adc_databus = adc; audio_ready = rdy; audio_in = ain;
    pos  = m_idx % 512;
    ramp = 10'(m_idx % 1021);
    case (mode)
      2'd0:    samp = adc;
      2'd1:    samp = ramp;
      2'd2:    samp = 10'h200;
      default: samp = ramp[0] ? 10'h2AA : 10'h155;
    endcase
    crc = crc_ref({m_snap[11:0], m_snap[23:12]});
    if (pos < 8)        side = sync_c[6*pos +: 6];
    else if (pos == 8)  side = m_snap[11:6];
    else if (pos == 9)  side = m_snap[5:0];
    else if (pos == 10) side = m_snap[23:18];
    else if (pos == 11) side = m_snap[17:12];
    else if (pos == 12) side = crc[11:6];
    else if (pos == 13) side = crc[5:0];
    else                side = 6'((m_idx % (63 * 65536)) / 65536);
    side2 = (pos < 14) ? side : 6'((m_idx % 16) / 4);
    if (rdy && m_seen) m_over = 1'b1;
    if (pos == 511) begin
      m_snap = rdy ? ain : m_pend; m_fresh = m_seen | rdy; m_seen = 1'b0;
    end else if (rdy) begin
      m_seen = 1'b1;
    end
    if (rdy) m_pend = ain;
    e.data = {side, samp}; e.data2 = {side2, samp}; e.fs = (pos == 0);
    e.fresh = m_fresh; e.over = m_over; e.pos = pos;
    exp_q.push_back(e);
    m_idx++;
    @(posedge clock);
    #1;
  endtask

  // Run until the audio slots of the frame after all requested strobes, scoreboarding every word
  task automatic run_frame(input int p1, input logic [23:0] v1, input int p2, input logic [23:0] v2,
                           input logic [1:0] mode, output logic [35:0] cap, output logic fresh_cap,
                           output logic ok);
    exp_t e;
    int   pos;
    logic rdy, d1, d2, crossed, got;
    logic [23:0] ain;
    d1 = 1'b0; d2 = 1'b0; crossed = 1'b0; got = 1'b0; cap = 36'd0; fresh_cap = 1'b0;
    for (int i = 0; i < 1600 && !got; i++) begin
      pos = m_idx % 512;
      rdy = 1'b0; ain = 24'($urandom);
      if (!d1 && pos == p1) begin
        rdy = 1'b1; ain = v1; d1 = 1'b1;
      end else if (d1 && !d2 && pos == p2) begin
        rdy = 1'b1; ain = v2; d2 = 1'b1;
      end
      if ((p1 < 0 || d1) && (p2 < 0 || d2) && pos == 0 && !rdy) crossed = 1'b1;
      cyc(mode, 10'($urandom), rdy, ain);
      e = exp_q.pop_front();
      n_cmp++;
      if (dataOut !== e.data || dataOut2 !== e.data2 || frameStart !== e.fs || frameStart2 !== e.fs ||
          audioFresh !== e.fresh || audioFresh2 !== e.fresh ||
          audioOverrun !== e.over || audioOverrun2 !== e.over) begin
        n_bad++;
        $display("FAIL word pos=%0d: got data=%h data2=%h fs=%b fresh=%b ovr=%b, want data=%h data2=%h fs=%b fresh=%b ovr=%b",
                 e.pos, dataOut, dataOut2, frameStart, audioFresh, audioOverrun,
                 e.data, e.data2, e.fs, e.fresh, e.over);
      end
      if (crossed && e.pos >= 8 && e.pos <= 13) begin
        cap[(13 - e.pos) * 6 +: 6] = dataOut[15:10];
        if (e.pos == 13) begin
          fresh_cap = audioFresh;
          got = 1'b1;
        end
      end
    end
    ok = got;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL run_frame timeout: got no audio slots, want slots 8..13 within 1600 clocks");
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (dataOut !== 16'd0 || dataOut2 !== 16'd0 ||
        {frameStart, frameStart2, audioFresh, audioFresh2, audioOverrun, audioOverrun2} !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_state: got data=%h data2=%h fs=%b fresh=%b ovr=%b, want all 0",
               dataOut, dataOut2, frameStart, audioFresh, audioOverrun);
    end
    @(negedge clock);
    nReset = 1'b1;
    model_reset();
  endtask

  task automatic test_ramp();
    exp_t e;
    int   fs_cnt;
    fs_cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      cyc(2'd1, 10'($urandom), 1'b0, 24'($urandom));
      e = exp_q.pop_front();
      n_cmp++;
      if (dataOut !== e.data || dataOut2 !== e.data2 || frameStart !== e.fs ||
          audioFresh !== e.fresh || audioOverrun !== e.over) begin
        n_bad++;
        $display("FAIL ramp word %0d: got data=%h data2=%h fs=%b fresh=%b ovr=%b, want data=%h data2=%h fs=%b fresh=%b ovr=%b",
                 i, dataOut, dataOut2, frameStart, audioFresh, audioOverrun,
                 e.data, e.data2, e.fs, e.fresh, e.over);
      end
      if (frameStart) fs_cnt++;
      if (i == 0 || i == 1021) begin
        n_cmp++;
        if (dataOut[9:0] !== 10'd0 || (i == 0 && dataOut[15:10] !== 6'h3E)) begin
          n_bad++;
          $display("FAIL ramp_wrap word %0d: got %h, want ramp 0 (side 3E on word 0)", i, dataOut);
        end
      end
    end
    n_cmp++;
    if (fs_cnt != 3) begin
      n_bad++;
      $display("FAIL frame_start_count: got %0d, want 3", fs_cnt);
    end
  endtask

  task automatic test_audio();
    logic [35:0] cap;
    logic        fr, ok;
    run_frame(200, 24'h123ABC, -1, 24'd0, 2'd0, cap, fr, ok);
    n_cmp++;
    if (cap !== {6'h2A, 6'h3C, 6'h04, 6'h23, crc_ref(24'hABC123)} || fr !== 1'b1) begin
      n_bad++;
      $display("FAIL audio_slots: got %h fresh=%b, want %h fresh=1", cap,
               fr, {6'h2A, 6'h3C, 6'h04, 6'h23, crc_ref(24'hABC123)});
    end
    run_frame(-1, 24'd0, -1, 24'd0, 2'd2, cap, fr, ok);
    n_cmp++;
    if (cap !== {6'h2A, 6'h3C, 6'h04, 6'h23, crc_ref(24'hABC123)} || fr !== 1'b0) begin
      n_bad++;
      $display("FAIL no_audio_repeat: got %h fresh=%b, want same slots fresh=0", cap, fr);
    end
  endtask

  task automatic test_overrun();
    logic [35:0] cap;
    logic        fr, ok;
    logic [23:0] v2;
    v2 = 24'h5E7C4D;
    n_cmp++;
    if (audioOverrun !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_initial: got %b, want 0", audioOverrun);
    end
    run_frame(100, 24'h0F1E2D, 300, v2, 2'd3, cap, fr, ok);
    n_cmp++;
    if (cap !== {v2[11:0], v2[23:12], crc_ref({v2[11:0], v2[23:12]})} || audioOverrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_newest: got %h ovr=%b, want %h ovr=1", cap, audioOverrun,
               {v2[11:0], v2[23:12], crc_ref({v2[11:0], v2[23:12]})});
    end
    run_frame(-1, 24'd0, -1, 24'd0, 2'd0, cap, fr, ok);
    n_cmp++;
    if (audioOverrun !== 1'b1 || fr !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_sticky: got ovr=%b fresh=%b, want ovr=1 fresh=0", audioOverrun, fr);
    end
  endtask

  task automatic test_bypass();
    logic [35:0] cap;
    logic        fr, ok;
    logic [23:0] v;
    v = 24'h9E3C71;
    run_frame(511, v, -1, 24'd0, 2'd1, cap, fr, ok);
    n_cmp++;
    if (cap !== {v[11:0], v[23:12], crc_ref({v[11:0], v[23:12]})} || fr !== 1'b1) begin
      n_bad++;
      $display("FAIL bypass_last_word: got %h fresh=%b, want %h fresh=1", cap, fr,
               {v[11:0], v[23:12], crc_ref({v[11:0], v[23:12]})});
    end
  endtask

  task automatic test_seq_reset();
    exp_t e;
    nReset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (dataOut !== 16'd0 || dataOut2 !== 16'd0 ||
          {frameStart, frameStart2, audioFresh, audioFresh2, audioOverrun, audioOverrun2} !== 6'd0) begin
        n_bad++;
        $display("FAIL midframe_reset %0d: got data=%h data2=%h fs=%b fresh=%b ovr=%b, want all 0",
                 k, dataOut, dataOut2, frameStart, audioFresh, audioOverrun);
      end
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    nReset = 1'b1;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      cyc(2'd1, 10'($urandom), 1'b0, 24'($urandom));
      e = exp_q.pop_front();
      n_cmp++;
      if (dataOut !== e.data || dataOut2 !== e.data2 || frameStart !== e.fs || frameStart2 !== e.fs ||
          audioFresh !== e.fresh || audioOverrun !== e.over) begin
        n_bad++;
        $display("FAIL restart word %0d: got data=%h data2=%h fs=%b, want data=%h data2=%h fs=%b",
                 e.pos, dataOut, dataOut2, frameStart, e.data, e.data2, e.fs);
      end
      if (e.pos == 0) begin
        n_cmp++;
        if (dataOut !== 16'hF800 || frameStart !== 1'b1) begin
          n_bad++;
          $display("FAIL restart_word0: got %h fs=%b, want f800 fs=1", dataOut, frameStart);
        end
      end
      if (e.pos >= 14 && e.pos <= 29) begin
        n_cmp++;
        if (dataOut2[15:10] !== {4'd0, seq_pat[e.pos % 16]}) begin
          n_bad++;
          $display("FAIL seq_small word %0d: got %h, want %h", e.pos, dataOut2[15:10],
                   {4'd0, seq_pat[e.pos % 16]});
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ramp();
    test_audio();
    test_overrun();
    test_bypass();
    test_seq_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
